// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Instruction-memory responder for the 4-bit accumulator core. A program is
//   streamed in byte by byte over a valid/ready interface into a local
//   DEPTH-entry store. The core is held in reset until a complete program has
//   been loaded, then released automatically. Fetches are served
//   combinationally from the store.
//
//   Optional build macro: IMEM_HALT_DETECT_EN
//     When defined, a taken branch-to-self in RUN sets a sticky HALTED flag.
//     When undefined, HALTED is tied low and no detection logic is built.
//
// Ports
//   CLK         in   rising-edge clock shared with the core
//   RST         in   asynchronous active-high reset
//   LD_START    in   single-cycle pulse, begins (or restarts) a program load
//   LD_VALID    in   host byte valid
//   LD_READY    out  a byte is accepted this cycle when LD_VALID is high
//   LD_DATA     in   instruction byte
//   LD_LAST     in   marks the final byte of the program
//   PC          in   core fetch address
//   INSTR       out  instruction at PC (8'h00 outside the loaded program)
//   CORE_RSTN   out  registered active-low reset to the core
//   LOADED_CNT  out  number of valid instructions stored
//   BUSY        out  high while loading
//   HALTED      out  sticky branch-to-self detect (optional feature)
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int unsigned PC_W    = 7,
    parameter int unsigned INSTR_W = 8,
    parameter int unsigned DEPTH   = 128,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               LD_START,
    input  logic               LD_VALID,
    output logic               LD_READY,
    input  logic [INSTR_W-1:0] LD_DATA,
    input  logic               LD_LAST,
    input  logic [PC_W-1:0]    PC,
    output logic [INSTR_W-1:0] INSTR,
    output logic               CORE_RSTN,
    output logic [CNT_W-1:0]   LOADED_CNT,
    output logic               BUSY,
    output logic               HALTED
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [PC_W-1:0]      r_wptr;
    logic [CNT_W-1:0]     r_loaded_cnt;
    logic                 r_core_rstn;
    logic [INSTR_W-1:0]   r_mem [DEPTH];

    logic                 w_beat;
    logic                 w_wptr_at_end;
    logic [CNT_W-1:0]     w_wptr_inc;
    logic [CNT_W-1:0]     w_pc_ext;
    logic [INSTR_W-1:0]   w_instr;

    assign w_wptr_at_end = (r_wptr == PC_W'(DEPTH - 1));
    assign w_wptr_inc    = CNT_W'(r_wptr) + CNT_W'(1);
    assign w_beat        = LD_VALID && LD_READY;

    // Next-state and combinational handshake/status outputs.
    always_comb begin
        w_next_state = r_state;
        LD_READY     = 1'b0;
        BUSY         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (LD_START) w_next_state = S_LOAD;
            end
            S_LOAD: begin
                BUSY     = 1'b1;
                LD_READY = !LD_START;
                // A restart takes priority over completing the current load.
                if (LD_START)
                    w_next_state = S_LOAD;
                else if (LD_VALID && (LD_LAST || w_wptr_at_end))
                    w_next_state = S_RUN;
            end
            S_RUN: begin
                if (LD_START) w_next_state = S_LOAD;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_wptr       <= '0;
            r_loaded_cnt <= '0;
            r_core_rstn  <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            // Registered from next state so the core is released on the same
            // edge that enters RUN and held on the same edge that leaves it.
            r_core_rstn <= (w_next_state == S_RUN);
            if (LD_START) begin
                r_wptr       <= '0;
                r_loaded_cnt <= '0;
            end else if (w_beat) begin
                r_loaded_cnt <= w_wptr_inc;
                // The last slot ends the load; hold the pointer rather than wrap.
                if (!w_wptr_at_end) r_wptr <= r_wptr + PC_W'(1);
            end
        end
    end

    // Store is not reset; only slots below LOADED_CNT are ever visible.
    always_ff @(posedge CLK) begin
        if (w_beat) r_mem[r_wptr] <= LD_DATA;
    end

    assign w_pc_ext = CNT_W'(PC);
    assign w_instr  = ((r_state == S_RUN) && (w_pc_ext < r_loaded_cnt)) ? r_mem[PC] : '0;
    assign INSTR      = w_instr;
    assign CORE_RSTN  = r_core_rstn;
    assign LOADED_CNT = r_loaded_cnt;

`ifdef IMEM_HALT_DETECT_EN
    logic [PC_W-1:0] r_prev_pc;
    logic            r_halted;
    logic            w_self_branch;

    // Branch opcode whose target is its own address, with PC not advancing.
    assign w_self_branch = (r_state == S_RUN) && w_instr[INSTR_W-1] &&
                           (w_instr[PC_W-1:0] == PC) && (PC == r_prev_pc);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_prev_pc <= '0;
            r_halted  <= 1'b0;
        end else begin
            r_prev_pc <= PC;
            if (LD_START)
                r_halted <= 1'b0;
            else if (w_self_branch)
                r_halted <= 1'b1;
        end
    end

    assign HALTED = r_halted;
`else
    assign HALTED = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Self-checking bench for imem_loader. Expected instruction bytes are pushed
//   to a scoreboard queue as they are streamed in and popped when the
//   corresponding PC is fetched. Honours IMEM_HALT_DETECT_EN for the HALTED
//   expectation.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    logic       CLK = 1'b0;
    logic       RST;
    logic       LD_START;
    logic       LD_VALID;
    logic       LD_READY;
    logic [7:0] LD_DATA;
    logic       LD_LAST;
    logic [6:0] PC;
    logic [7:0] INSTR;
    logic       CORE_RSTN;
    logic [7:0] LOADED_CNT;
    logic       BUSY;
    logic       HALTED;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] sb_q[$];
    logic [7:0] exp_b;

`ifdef IMEM_HALT_DETECT_EN
    localparam logic HALT_EXP = 1'b1;
`else
    localparam logic HALT_EXP = 1'b0;
`endif

    always #5 CLK = ~CLK;

    imem_loader #(
        .PC_W   (7),
        .INSTR_W(8),
        .DEPTH  (128),
        .CNT_W  (8)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .LD_START  (LD_START),
        .LD_VALID  (LD_VALID),
        .LD_READY  (LD_READY),
        .LD_DATA   (LD_DATA),
        .LD_LAST   (LD_LAST),
        .PC        (PC),
        .INSTR     (INSTR),
        .CORE_RSTN (CORE_RSTN),
        .LOADED_CNT(LOADED_CNT),
        .BUSY      (BUSY),
        .HALTED    (HALTED)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic test_reset();
        logic [6:0] pcs[3];
        pcs = '{7'd0, 7'd64, 7'd127};
        @(negedge CLK); RST = 1'b1;
        @(negedge CLK); RST = 1'b0;
        repeat (5) @(negedge CLK);
        #1;
        n_checks++; if (CORE_RSTN !== 1'b0) begin n_errors++; $display("FAIL reset_core_rstn: got %b expected 0", CORE_RSTN); end
        n_checks++; if (LD_READY !== 1'b0) begin n_errors++; $display("FAIL reset_ld_ready: got %b expected 0", LD_READY); end
        n_checks++; if (LOADED_CNT !== 8'd0) begin n_errors++; $display("FAIL reset_loaded_cnt: got %0d expected 0", LOADED_CNT); end
        n_checks++; if (BUSY !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
        n_checks++; if (HALTED !== 1'b0) begin n_errors++; $display("FAIL reset_halted: got %b expected 0", HALTED); end
        for (int i = 0; i < 3; i++) sb_q.push_back(8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK); PC = pcs[i]; #1;
            exp_b = sb_q.pop_front();
            n_checks++; if (INSTR !== exp_b) begin n_errors++; $display("FAIL reset_instr pc=%0d: got %h expected %h", PC, INSTR, exp_b); end
        end
    endtask

    task automatic test_basic_load();
        logic [7:0] prog[3];
        int busy_cycles;
        prog = '{8'h41, 8'h52, 8'h80};
        busy_cycles = 0;
        @(negedge CLK); LD_START = 1'b1;
        @(negedge CLK); LD_START = 1'b0;
        for (int i = 0; i < 3; i++) begin
            LD_VALID = 1'b1; LD_DATA = prog[i]; LD_LAST = (i == 2);
            sb_q.push_back(prog[i]);
            #1;
            if (BUSY === 1'b1) busy_cycles++;
            if (i == 2) begin
                n_checks++; if (CORE_RSTN !== 1'b0) begin n_errors++; $display("FAIL basic_rstn_before_edge: got %b expected 0", CORE_RSTN); end
            end
            @(negedge CLK);
        end
        LD_VALID = 1'b0; LD_LAST = 1'b0; #1;
        n_checks++; if (busy_cycles != 3) begin n_errors++; $display("FAIL basic_busy_cycles: got %0d expected 3", busy_cycles); end
        n_checks++; if (BUSY !== 1'b0) begin n_errors++; $display("FAIL basic_busy_after: got %b expected 0", BUSY); end
        n_checks++; if (CORE_RSTN !== 1'b1) begin n_errors++; $display("FAIL basic_core_rstn: got %b expected 1", CORE_RSTN); end
        n_checks++; if (LOADED_CNT !== 8'd3) begin n_errors++; $display("FAIL basic_loaded_cnt: got %0d expected 3", LOADED_CNT); end
        sb_q.push_back(8'h00);
        for (int pc = 0; pc < 4; pc++) begin
            @(negedge CLK); PC = 7'(pc); #1;
            exp_b = sb_q.pop_front();
            n_checks++; if (INSTR !== exp_b) begin n_errors++; $display("FAIL basic_instr pc=%0d: got %h expected %h", pc, INSTR, exp_b); end
        end
    endtask

    task automatic test_valid_gaps();
        @(negedge CLK); LD_START = 1'b1;
        @(negedge CLK); LD_START = 1'b0;
        for (int i = 0; i < 8; i++) begin
            LD_VALID = ((i % 2) == 0);
            LD_DATA  = 8'hA0 + 8'(i);
            // LD_LAST on an idle cycle (i==5) must not end the load.
            LD_LAST  = (i == 5) || (i == 6);
            if ((i % 2) == 0) sb_q.push_back(8'hA0 + 8'(i));
            @(negedge CLK);
        end
        LD_VALID = 1'b0; LD_LAST = 1'b0; #1;
        n_checks++; if (LOADED_CNT !== 8'd4) begin n_errors++; $display("FAIL gaps_loaded_cnt: got %0d expected 4", LOADED_CNT); end
        n_checks++; if (CORE_RSTN !== 1'b1) begin n_errors++; $display("FAIL gaps_core_rstn: got %b expected 1", CORE_RSTN); end
        sb_q.push_back(8'h00);
        for (int pc = 0; pc < 5; pc++) begin
            @(negedge CLK); PC = 7'(pc); #1;
            exp_b = sb_q.pop_front();
            n_checks++; if (INSTR !== exp_b) begin n_errors++; $display("FAIL gaps_instr pc=%0d: got %h expected %h", pc, INSTR, exp_b); end
        end
    endtask

    task automatic test_full_load();
        logic [6:0] pcs[3];
        pcs = '{7'd127, 7'd0, 7'd64};
        @(negedge CLK); LD_START = 1'b1;
        @(negedge CLK); LD_START = 1'b0;
        for (int i = 0; i < 128; i++) begin
            LD_VALID = 1'b1; LD_DATA = 8'(i); LD_LAST = 1'b0;
            if (i == 127) begin
                #1;
                n_checks++; if (LD_READY !== 1'b1) begin n_errors++; $display("FAIL full_ready_last_slot: got %b expected 1", LD_READY); end
                n_checks++; if (LOADED_CNT !== 8'd127) begin n_errors++; $display("FAIL full_cnt_before_last: got %0d expected 127", LOADED_CNT); end
            end
            @(negedge CLK);
        end
        LD_VALID = 1'b0; #1;
        n_checks++; if (CORE_RSTN !== 1'b1) begin n_errors++; $display("FAIL full_core_rstn: got %b expected 1", CORE_RSTN); end
        n_checks++; if (LOADED_CNT !== 8'd128) begin n_errors++; $display("FAIL full_loaded_cnt: got %0d expected 128", LOADED_CNT); end
        n_checks++; if (BUSY !== 1'b0) begin n_errors++; $display("FAIL full_busy: got %b expected 0", BUSY); end
        sb_q.push_back(8'h7F); sb_q.push_back(8'h00); sb_q.push_back(8'h40);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK); PC = pcs[i]; #1;
            exp_b = sb_q.pop_front();
            n_checks++; if (INSTR !== exp_b) begin n_errors++; $display("FAIL full_instr pc=%0d: got %h expected %h", PC, INSTR, exp_b); end
        end
    endtask

    task automatic test_restart();
        @(negedge CLK); PC = 7'd127; LD_START = 1'b1; #1;
        n_checks++; if (LD_READY !== 1'b0) begin n_errors++; $display("FAIL restart_ready_in_run: got %b expected 0", LD_READY); end
        @(negedge CLK); LD_START = 1'b0; #1;
        n_checks++; if (CORE_RSTN !== 1'b0) begin n_errors++; $display("FAIL restart_core_rstn: got %b expected 0", CORE_RSTN); end
        n_checks++; if (LOADED_CNT !== 8'd0) begin n_errors++; $display("FAIL restart_cnt_cleared: got %0d expected 0", LOADED_CNT); end
        n_checks++; if (BUSY !== 1'b1) begin n_errors++; $display("FAIL restart_busy: got %b expected 1", BUSY); end
        n_checks++; if (INSTR !== 8'h00) begin n_errors++; $display("FAIL restart_instr_held: got %h expected 00", INSTR); end
        LD_VALID = 1'b1; LD_DATA = 8'h11; LD_LAST = 1'b0;
        @(negedge CLK);
        LD_START = 1'b1; LD_DATA = 8'h22; LD_LAST = 1'b1; #1;
        n_checks++; if (LD_READY !== 1'b0) begin n_errors++; $display("FAIL restart_coincident_ready: got %b expected 0", LD_READY); end
        n_checks++; if (LOADED_CNT !== 8'd1) begin n_errors++; $display("FAIL restart_partial_cnt: got %0d expected 1", LOADED_CNT); end
        @(negedge CLK);
        LD_START = 1'b0; LD_DATA = 8'h4F; LD_LAST = 1'b1; #1;
        n_checks++; if (LOADED_CNT !== 8'd0) begin n_errors++; $display("FAIL restart_dropped_cnt: got %0d expected 0", LOADED_CNT); end
        n_checks++; if (BUSY !== 1'b1) begin n_errors++; $display("FAIL restart_still_loading: got %b expected 1", BUSY); end
        sb_q.push_back(8'h4F);
        @(negedge CLK);
        LD_VALID = 1'b0; LD_LAST = 1'b0; #1;
        n_checks++; if (LOADED_CNT !== 8'd1) begin n_errors++; $display("FAIL reload_cnt: got %0d expected 1", LOADED_CNT); end
        n_checks++; if (CORE_RSTN !== 1'b1) begin n_errors++; $display("FAIL reload_core_rstn: got %b expected 1", CORE_RSTN); end
        sb_q.push_back(8'h00);
        for (int pc = 0; pc < 2; pc++) begin
            @(negedge CLK); PC = 7'(pc); #1;
            exp_b = sb_q.pop_front();
            n_checks++; if (INSTR !== exp_b) begin n_errors++; $display("FAIL reload_instr pc=%0d: got %h expected %h", pc, INSTR, exp_b); end
        end
    endtask

    task automatic test_halt();
        @(negedge CLK); LD_START = 1'b1; PC = 7'd0;
        @(negedge CLK); LD_START = 1'b0;
        LD_VALID = 1'b1; LD_DATA = 8'h4F; LD_LAST = 1'b0;
        @(negedge CLK); LD_DATA = 8'h81; LD_LAST = 1'b1;
        @(negedge CLK); LD_VALID = 1'b0; LD_LAST = 1'b0; #1;
        n_checks++; if (HALTED !== 1'b0) begin n_errors++; $display("FAIL halt_initial: got %b expected 0", HALTED); end
        // Not-taken: PC sits on the branch for one cycle, then advances.
        @(negedge CLK); PC = 7'd1; #1;
        n_checks++; if (INSTR !== 8'h81) begin n_errors++; $display("FAIL halt_branch_instr: got %h expected 81", INSTR); end
        @(negedge CLK); PC = 7'd2; #1;
        n_checks++; if (HALTED !== 1'b0) begin n_errors++; $display("FAIL halt_not_taken: got %b expected 0", HALTED); end
        @(negedge CLK); #1;
        n_checks++; if (HALTED !== 1'b0) begin n_errors++; $display("FAIL halt_not_taken_late: got %b expected 0", HALTED); end
        // Taken: PC held on the branch for two cycles.
        @(negedge CLK); PC = 7'd1;
        @(negedge CLK); #1;
        n_checks++; if (HALTED !== 1'b0) begin n_errors++; $display("FAIL halt_first_hold: got %b expected 0", HALTED); end
        @(negedge CLK); #1;
        n_checks++; if (HALTED !== HALT_EXP) begin n_errors++; $display("FAIL halt_taken: got %b expected %b", HALTED, HALT_EXP); end
        @(negedge CLK); PC = 7'd2;
        @(negedge CLK); #1;
        n_checks++; if (HALTED !== HALT_EXP) begin n_errors++; $display("FAIL halt_sticky: got %b expected %b", HALTED, HALT_EXP); end
        LD_START = 1'b1;
        @(negedge CLK); LD_START = 1'b0; #1;
        n_checks++; if (HALTED !== 1'b0) begin n_errors++; $display("FAIL halt_cleared: got %b expected 0", HALTED); end
    endtask

    initial begin
        RST = 1'b1; LD_START = 1'b0; LD_VALID = 1'b0; LD_DATA = 8'h00;
        LD_LAST = 1'b0; PC = 7'd0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        test_reset();
        test_basic_load();
        test_valid_gaps();
        test_full_load();
        test_restart();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Instruction-memory responder for the 4-bit accumulator core. It serves `INSTR` for the core's `PC` fetch requests.
- Programs are loaded over a byte-wide valid/ready stream into a local 128-entry store.
- The core is held in reset via `CORE_RSTN` until a complete program is present. Release happens automatically after the last byte.
- Sits between the test/boot host and the core; the core's `PC`/`INSTR` ports connect directly to this block.

Parameters:
- `PC_W`, 7, width of the core program counter.
- `INSTR_W`, 8, instruction width.
- `DEPTH`, 128, number of instruction slots; equals 2**`PC_W`.
- `CNT_W`, 8, width of the loaded-count register; must hold `DEPTH`.

Ports:
- `CLK`  in  1  rising-edge clock shared with the core
- `RST`  in  1  asynchronous, active-high reset
- `LD_START`  in  1  single-cycle pulse; begins a new program load
- `LD_VALID`  in  1  host byte valid
- `LD_READY`  out  1  block accepts a byte this cycle
- `LD_DATA`  in  `INSTR_W`  instruction byte
- `LD_LAST`  in  1  marks the final byte of the program
- `PC`  in  `PC_W`  core fetch address
- `INSTR`  out  `INSTR_W`  instruction for the current `PC`
- `CORE_RSTN`  out  1  active-low reset to the core
- `LOADED_CNT`  out  `CNT_W`  number of valid instructions stored
- `BUSY`  out  1  high while in `LOAD`
- `HALTED`  out  1  halt detect; see Optional Feature

Behaviour:
- One clock domain. Reset is asynchronous and active-high on `RST`.
- Reset values: state=`IDLE`, `CORE_RSTN`=0, `LOADED_CNT`=0, write pointer=0, `HALTED`=0. Memory contents are not reset.
- States: `IDLE` (no program, core held), `LOAD` (accepting bytes, core held), `RUN` (core released).
- Combinational outputs:
  - `BUSY` = (state==`LOAD`).
  - `LD_READY` = (state==`LOAD`) && !`LD_START`.
- `IDLE`:
  - `LD_START` -> `LOAD` next edge; clear wptr and `LOADED_CNT`.
  - `LD_VALID` is ignored.
- `LOAD`:
  - A beat is `LD_VALID` && `LD_READY`.
  - On a beat: mem[wptr] <= `LD_DATA`; wptr <= wptr+1; `LOADED_CNT` <= wptr+1.
  - Beat with `LD_LAST`=1, or a beat at wptr==`DEPTH`-1 -> `RUN` next edge.
  - A byte arriving at wptr==`DEPTH`-1 is the final byte and is stored; no wptr overflow.
  - `LD_START` in `LOAD` restarts: wptr=0, `LOADED_CNT`=0, and the coincident byte is not accepted (`LD_READY` is low).
- `RUN`:
  - `LD_START` -> `LOAD` next edge and clears count.
  - `LD_VALID` is ignored.
- `CORE_RSTN` is registered and equals (next_state==`RUN`). It rises on the same edge the state enters `RUN`, and falls on the same edge the state leaves `RUN`.
- `INSTR` is a combinational read, zero latency; the core samples it in the same cycle `PC` is presented.
  - `INSTR` = mem[`PC`] if state==`RUN` && `PC` < `LOADED_CNT`, else 8'h00.
  - 8'h00 is ADD r0, i.e. a harmless no-op in effect.
- Zero-length programs are impossible: `LD_LAST` is only meaningful on a beat.
- A write to mem[k] never occurs in `RUN`, so there are no read/write collisions while the core executes.

Optional Feature:
- Macro: `IMEM_HALT_DETECT_EN`.
- With the macro defined:
  - In `RUN`, the block flags a taken branch-to-self: `INSTR`[7]==1 and `INSTR`[6:0]==`PC` while `PC` equals its previous-cycle value.
  - On that condition `HALTED` sets to 1 at the next edge.
  - `HALTED` is sticky until `RST` or `LD_START`.
  - A not-taken branch-to-self advances `PC` and does not set `HALTED`.
- Without the macro: `HALTED` is tied to 0; no comparator or previous-`PC` register is built.

Test Plan:
- `RST` pulse then idle 5 cycles -> `CORE_RSTN`=0, `LD_READY`=0, `INSTR`=8'h00 for any `PC`, `LOADED_CNT`=0.
- `LD_START`, then bytes 8'h41, 8'h52, 8'h80 with `LD_LAST` on the third byte, back-to-back -> `BUSY` for 3 cycles.
  - `LOADED_CNT`=3, and `CORE_RSTN` rises on the edge after the third beat.
  - `PC`=0,1,2,3 -> `INSTR`=8'h41, 8'h52, 8'h80, 8'h00.
- Load with `LD_VALID` toggling 1,0,1,0 -> only cycles with valid count as beats; each byte lands at the consecutive address and no byte is skipped.
- Stream 128 bytes (value = index) with `LD_LAST`=0 -> auto-transition to `RUN` after byte 127, `LOADED_CNT`=128, `PC`=127 -> `INSTR`=8'h7F.
- Mid-`RUN` `LD_START` -> `CORE_RSTN` falls next edge and `INSTR`=8'h00.
  - Reload of 1 byte 8'h4F with `LD_LAST` -> `LOADED_CNT`=1, `PC`=1 reads 8'h00.
  - `LD_START` coincident with a valid byte in `LOAD` -> that byte is dropped and wptr=0.
- With `IMEM_HALT_DETECT_EN`: program {8'h4F, 8'h81} (ADDI 15 then branch to 1), `PC` held at 1 for two cycles -> `HALTED`=1; `LD_START` clears it.
  - Without the macro, the same stimulus keeps `HALTED`=0.
